// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and constants for the sequence-detector scheduler
// Purpose: FSM state encoding, default pattern and per-channel context widths.
// Ports: none (package).
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int DEF_PLEN = 4;
  localparam logic [DEF_PLEN-1:0] DEF_PATTERN = 4'b0110;

  // hist keeps the last PLEN-1 bits seen; fill saturates at PLEN-1
  function automatic int hist_width(input int plen);
    return plen - 1;
  endfunction

  function automatic int fill_width(input int plen);
    return $clog2(plen);
  endfunction

endpackage

// File: rtl/seq_det_core.sv
// rtl/seq_det_core.sv - combinational single-bit step of the pattern detector
// Purpose: given a channel context (hist, fill) and the next bit x, produce the
//          updated context and the match flag z. Holds no state.
// Ports:
//   hist     in   PLEN-1   last bits seen, oldest in MSB
//   fill     in   FW       number of valid bits in hist (saturating)
//   x        in   1        incoming bit
//   hist_nxt out  PLEN-1   updated history
//   fill_nxt out  FW       updated fill count
//   z        out  1        a full pattern completed on this bit
module seq_det_core
  import seq_det_pkg::*;
#(
  parameter int              PLEN    = DEF_PLEN,
  parameter logic [PLEN-1:0] PATTERN = PLEN'(DEF_PATTERN)
) (
  input  logic [hist_width(PLEN)-1:0] hist,
  input  logic [fill_width(PLEN)-1:0] fill,
  input  logic                        x,
  output logic [hist_width(PLEN)-1:0] hist_nxt,
  output logic [fill_width(PLEN)-1:0] fill_nxt,
  output logic                        z
);

  localparam int HW = hist_width(PLEN);
  localparam int FW = fill_width(PLEN);

  logic [PLEN-1:0] win;
  logic            full;

  assign win      = {hist, x};
  assign full     = (fill == FW'(PLEN - 1));
  // the new history is simply the youngest PLEN-1 bits of the window
  assign hist_nxt = win[HW-1:0];
  assign fill_nxt = full ? fill : fill + FW'(1);
  assign z        = full && (win == PATTERN);

endmodule

// File: rtl/seq_det_scheduler.sv
// rtl/seq_det_scheduler.sv - round-robin time-multiplexing of one pattern detector over NCH channels
// Purpose: grants requesting channels round-robin, shifts the granted word
//          MSB-first through seq_det_core with that channel's saved context,
//          reports a per-bit match mask and writes the context back.
// Ports:
//   clk         in   1            rising-edge clock
//   reset_n     in   1            asynchronous active-low reset
//   req_valid   in   NCH          channel i has a word pending
//   req_data    in   NCH*W        word of channel i at [i*W +: W]
//   req_ready   out  NCH          one-hot accept pulse (IDLE only)
//   ch_clear    in   NCH          zero the saved context of channel i
//   busy        out  1            high in SHIFT and DONE
//   done        out  1            one-cycle result strobe
//   done_ch     out  clog2(NCH)   channel of the current result
//   match_mask  out  W            bit k set = match completed on word bit k
//   match_cnt   out  clog2(W+1)   popcount of match_mask
module seq_det_scheduler
  import seq_det_pkg::*;
#(
  parameter int              NCH     = 4,
  parameter int              W       = 8,
  parameter int              PLEN    = DEF_PLEN,
  parameter logic [PLEN-1:0] PATTERN = PLEN'(DEF_PATTERN)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NCH-1:0]           req_valid,
  input  logic [NCH*W-1:0]         req_data,
  output logic [NCH-1:0]           req_ready,
  input  logic [NCH-1:0]           ch_clear,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NCH)-1:0]   done_ch,
  output logic [W-1:0]             match_mask,
  output logic [$clog2(W+1)-1:0]   match_cnt
);

  localparam int CW   = $clog2(NCH);
  localparam int CNTW = $clog2(W + 1);
  localparam int BW   = (W > 1) ? $clog2(W) : 1;
  localparam int HW   = hist_width(PLEN);
  localparam int FW   = fill_width(PLEN);

  state_t          state, state_nxt;
  logic [CW-1:0]   ptr;
  logic [CW-1:0]   grant_ch;
  logic [CW-1:0]   pick;
  logic            grant_en;

  logic [W-1:0]    word;
  logic [BW-1:0]   bit_idx;
  logic [W-1:0]    work_mask;
  logic [W-1:0]    mask_nxt;
  logic [CNTW-1:0] cnt_nxt;
  logic            last_bit;

  logic [HW-1:0]   cur_hist, hist_nxt;
  logic [FW-1:0]   cur_fill, fill_nxt;
  logic            z;
  logic            clr_pend;

  logic [HW-1:0]   hist_mem [NCH];
  logic [FW-1:0]   fill_mem [NCH];
  logic [W-1:0]    req_word [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_word
    assign req_word[i] = req_data[i*W +: W];
  end

  // First valid channel strictly after p, wrapping; scanning offsets from
  // largest to smallest lets the nearest channel overwrite farther ones.
  function automatic logic [CW-1:0] rr_pick(input logic [NCH-1:0] v, input logic [CW-1:0] p);
    logic [CW-1:0] r;
    int            idx;
    r = p;
    for (int off = NCH; off >= 1; off--) begin
      idx = (int'(p) + off) % NCH;
      if (v[idx]) r = CW'(idx);
    end
    return r;
  endfunction

  assign pick = rr_pick(req_valid, ptr);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    grant_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        // reset_n gate keeps req_ready low while reset is held
        if (reset_n && (|req_valid)) begin
          grant_en        = 1'b1;
          req_ready[pick] = 1'b1;
          state_nxt       = ST_SHIFT;
        end
      end
      ST_SHIFT: if (last_bit) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // ---------------------------------------------------------------- core
  seq_det_core #(
    .PLEN    (PLEN),
    .PATTERN (PATTERN)
  ) u_core (
    .hist     (cur_hist),
    .fill     (cur_fill),
    .x        (word[bit_idx]),
    .hist_nxt (hist_nxt),
    .fill_nxt (fill_nxt),
    .z        (z)
  );

  assign last_bit = (bit_idx == '0);
  assign mask_nxt = work_mask | (W'(z) << bit_idx);

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < W; i++) cnt_nxt = cnt_nxt + CNTW'(mask_nxt[i]);
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr        <= CW'(NCH - 1);
      grant_ch   <= '0;
      word       <= '0;
      bit_idx    <= '0;
      work_mask  <= '0;
      cur_hist   <= '0;
      cur_fill   <= '0;
      clr_pend   <= 1'b0;
      done_ch    <= '0;
      match_mask <= '0;
      match_cnt  <= '0;
      for (int i = 0; i < NCH; i++) begin
        hist_mem[i] <= '0;
        fill_mem[i] <= '0;
      end
    end else begin
      if (grant_en) begin
        grant_ch  <= pick;
        ptr       <= pick;
        word      <= req_word[pick];
        bit_idx   <= BW'(W - 1);
        work_mask <= '0;
        // a clear arriving on the grant cycle must not be bypassed by the latch
        cur_hist  <= ch_clear[pick] ? '0 : hist_mem[pick];
        cur_fill  <= ch_clear[pick] ? '0 : fill_mem[pick];
      end

      if (state == ST_SHIFT) begin
        cur_hist  <= hist_nxt;
        cur_fill  <= fill_nxt;
        work_mask <= mask_nxt;
        bit_idx   <= bit_idx - BW'(1);
        if (last_bit) begin
          // results become visible in DONE and hold until the next DONE
          match_mask <= mask_nxt;
          match_cnt  <= cnt_nxt;
          done_ch    <= grant_ch;
        end
      end

      if (grant_en)
        clr_pend <= 1'b0;
      else if ((state != ST_IDLE) && ch_clear[grant_ch])
        clr_pend <= 1'b1;

      // clear has priority over write-back
      for (int i = 0; i < NCH; i++) begin
        if (ch_clear[i]) begin
          hist_mem[i] <= '0;
          fill_mem[i] <= '0;
        end else if ((state == ST_DONE) && (grant_ch == CW'(i))) begin
          hist_mem[i] <= clr_pend ? '0 : cur_hist;
          fill_mem[i] <= clr_pend ? '0 : cur_fill;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_det_scheduler.sv
// tb/tb_seq_det_scheduler.sv - directed self-checking bench for seq_det_scheduler
module tb_seq_det_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [3:0]  ch_clear = '0;
  logic        busy;
  logic        done;
  logic [1:0]  done_ch;
  logic [7:0]  match_mask;
  logic [3:0]  match_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  seq_det_scheduler #(
    .NCH     (4),
    .W       (8),
    .PLEN    (4),
    .PATTERN (4'b0110)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .ch_clear   (ch_clear),
    .busy       (busy),
    .done       (done),
    .done_ch    (done_ch),
    .match_mask (match_mask),
    .match_cnt  (match_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // offer one word on channel ch; optionally pulse ch_clear[ch] at SHIFT/DONE
  // cycle clr_at (1..8 = SHIFT, 9 = DONE, 0 = never); check result and timing
  task automatic send(input int ch, input logic [7:0] data, input logic [7:0] emask,
                      input int clr_at, input string tag);
    int n;
    int lat;
    bit got;
    @(negedge clk);
    req_data[ch*8 +: 8] = data;
    req_valid[ch] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[ch] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".ready"}, req_ready[ch], 1);
    @(posedge clk);
    #1;
    req_valid[ch] = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      ch_clear[ch] = (lat == clr_at);
      if (done) got = 1'b1;
    end
    chk({tag, ".latency"}, lat, 9);
    chk({tag, ".done_ch"}, done_ch, ch);
    chk({tag, ".mask"}, match_mask, emask);
    chk({tag, ".cnt"}, match_cnt, $countones(emask));
    @(negedge clk);
    ch_clear = '0;
    chk({tag, ".done_pulse"}, done, 0);
  endtask

  initial begin : stim
    int ng;
    int nd;
    int n_done;

    do_reset();
    @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.ready", req_ready, 0);
    chk("rst.mask", match_mask, 0);
    chk("rst.cnt", match_cnt, 0);
    chk("rst.done_ch", done_ch, 0);

    // 1: overlapping matches in one word
    send(0, 8'b0110_1100, 8'b0001_0010, 0, "t1");

    // 2: match spanning two words of the same channel
    send(1, 8'h03, 8'h00, 0, "t2a");
    send(1, 8'h7F, 8'h80, 0, "t2b");

    // 3: contexts isolated between channels
    send(2, 8'h03, 8'h00, 0, "t3a");
    send(3, 8'h00, 8'h00, 0, "t3b");
    send(2, 8'h7F, 8'h80, 0, "t3c");

    // 6: reset mid-SHIFT aborts and wipes contexts
    send(1, 8'h03, 8'h00, 0, "t6pre1");
    send(2, 8'h6C, 8'h12, 0, "t6pre2");
    @(negedge clk);
    req_data[15:8] = 8'h03;
    req_valid[1] = 1'b1;
    #1;
    chk("t6.ready", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6.busy_pre", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("t6.busy", busy, 0);
    chk("t6.done", done, 0);
    chk("t6.mask", match_mask, 0);
    chk("t6.cnt", match_cnt, 0);
    chk("t6.done_ch", done_ch, 0);
    chk("t6.ready0", req_ready, 0);
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) n_done++;
    end
    reset_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("t6.no_done", n_done, 0);
    send(1, 8'h7F, 8'h00, 0, "t6post");

    // 4: all channels requesting from reset -> ch0,1,2,3,0 every 10 cycles
    do_reset();
    @(negedge clk);
    req_data = '0;
    req_valid = 4'hF;
    #1;
    ng = 0;
    nd = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (req_ready != 4'h0) begin
        chk("t4.onehot", $countones(req_ready), 1);
        chk($sformatf("t4.grant%0d", ng), req_ready, 32'd1 << (ng % 4));
        chk($sformatf("t4.time%0d", ng), cyc, ng * 10);
        ng++;
      end
      if (done) begin
        chk($sformatf("t4.done_ch%0d", nd), done_ch, nd % 4);
        chk($sformatf("t4.done_time%0d", nd), cyc, nd * 10 + 9);
        nd++;
      end
      if (cyc == 49) req_valid = '0;
    end
    chk("t4.ngrants", ng, 5);
    chk("t4.ndones", nd, 5);

    // 5: ch_clear in IDLE, in SHIFT and in DONE each break the cross-word match
    do_reset();
    send(1, 8'h03, 8'h00, 0, "t5a");
    @(negedge clk);
    ch_clear[1] = 1'b1;
    @(negedge clk);
    ch_clear = '0;
    send(1, 8'h7F, 8'h00, 0, "t5b");
    send(1, 8'h03, 8'h00, 3, "t5c");
    send(1, 8'h7F, 8'h00, 0, "t5d");
    send(1, 8'h03, 8'h00, 9, "t5e");
    send(1, 8'h7F, 8'h00, 0, "t5f");
    // without a clear the same pair still matches
    send(1, 8'h03, 8'h00, 0, "t5g");
    send(1, 8'h7F, 8'h80, 0, "t5h");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
